// File: rtl/wfg_stim_sweep_pkg.sv
// Shared types and constants for the sine-stimulus frequency-sweep scheduler.
package wfg_stim_sweep_pkg;

  localparam int INC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wfg_stim_sweep_states_t;

  localparam logic SWEEP_ONESHOT = 1'b0;
  localparam logic SWEEP_CONT    = 1'b1;

endpackage

// File: rtl/wfg_stim_sweep_step.sv
// Next-increment arithmetic: add (or subtract when sweeping down) one step and
// flag the step that would cross the stop limit or overflow 16 bits.
import wfg_stim_sweep_pkg::*;

module wfg_stim_sweep_step (
  input  logic [INC_W-1:0] inc,
  input  logic [INC_W-1:0] step,
  input  logic [INC_W-1:0] stop,
  input  logic             down,
  output logic [INC_W-1:0] nxt,
  output logic             last
);

  logic [INC_W:0] sum_s;
  logic [INC_W:0] diff_s;

  // Bit 16 of sum/diff is the carry/borrow that also ends the sweep.
  always_comb begin
    sum_s  = {1'b0, inc} + {1'b0, step};
    diff_s = {1'b0, inc} - {1'b0, step};
    if (down) begin
      nxt  = diff_s[INC_W-1:0];
      last = diff_s[INC_W] | (diff_s[INC_W-1:0] < stop);
    end else begin
      nxt  = sum_s[INC_W-1:0];
      last = sum_s[INC_W] | (sum_s[INC_W-1:0] > stop);
    end
  end

endmodule

// File: rtl/wfg_stim_sweep_ctrl.sv
// Frequency-sweep scheduler driving the sine generator enable/increment.
// Optional bidirectional sweeps: define WFG_STIM_SWEEP_DOWN_EN.
import wfg_stim_sweep_pkg::*;

module wfg_stim_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_en_q_i,
  input  logic               ctrl_mode_q_i,
  input  logic [INC_W-1:0]   start_inc_q_i,
  input  logic [INC_W-1:0]   stop_inc_q_i,
  input  logic [INC_W-1:0]   step_inc_q_i,
  input  logic [DWELL_W-1:0] dwell_q_i,
  input  logic               gen_axis_tvalid_i,
  input  logic               gen_axis_tready_i,
  output logic               gen_en_o,
  output logic [INC_W-1:0]   gen_inc_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wrap_o,
  output logic [INC_W-1:0]   step_idx_o
);

  wfg_stim_sweep_states_t state_r, state_nxt_s;

  logic [INC_W-1:0]   start_sh_r, stop_sh_r, step_sh_r;
  logic [DWELL_W-1:0] dwell_sh_r;
  logic               mode_sh_r, down_sh_r;

  logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nxt_s, dwell_eff_s;
  logic               gen_en_r, gen_en_nxt_s;
  logic [INC_W-1:0]   gen_inc_r, gen_inc_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               wrap_r, wrap_nxt_s;
  logic [INC_W-1:0]   step_idx_r, step_idx_nxt_s;

  logic               acc_s, step_end_s, load_s;
  logic [INC_W-1:0]   step_nxt_s;
  logic               step_last_s;

  assign acc_s       = gen_axis_tvalid_i & gen_axis_tready_i;
  assign dwell_eff_s = (dwell_sh_r == {DWELL_W{1'b0}}) ? DWELL_W'(1) : dwell_sh_r;
  assign step_end_s  = acc_s & (dwell_cnt_r == (dwell_eff_s - DWELL_W'(1)));

  wfg_stim_sweep_step u_step (
    .inc  (gen_inc_r),
    .step (step_sh_r),
    .stop (stop_sh_r),
    .down (down_sh_r),
    .nxt  (step_nxt_s),
    .last (step_last_s)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_nxt_s     = state_r;
    gen_en_nxt_s    = 1'b0;
    gen_inc_nxt_s   = gen_inc_r;
    busy_nxt_s      = 1'b0;
    done_nxt_s      = 1'b0;
    wrap_nxt_s      = 1'b0;
    step_idx_nxt_s  = step_idx_r;
    dwell_cnt_nxt_s = dwell_cnt_r;
    load_s          = 1'b0;
    case (state_r)
      IDLE: begin
        gen_inc_nxt_s   = {INC_W{1'b0}};
        step_idx_nxt_s  = {INC_W{1'b0}};
        dwell_cnt_nxt_s = {DWELL_W{1'b0}};
        if (ctrl_en_q_i) begin
          load_s        = 1'b1;
          state_nxt_s   = RUN;
          gen_en_nxt_s  = 1'b1;
          busy_nxt_s    = 1'b1;
          gen_inc_nxt_s = start_inc_q_i;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // Dropping enable wins over any accept or step end in the same cycle.
        if (!ctrl_en_q_i) begin
          state_nxt_s     = IDLE;
          gen_inc_nxt_s   = {INC_W{1'b0}};
          step_idx_nxt_s  = {INC_W{1'b0}};
          dwell_cnt_nxt_s = {DWELL_W{1'b0}};
        end else begin
          gen_en_nxt_s = 1'b1;
          busy_nxt_s   = 1'b1;
          if (step_end_s) begin
            dwell_cnt_nxt_s = {DWELL_W{1'b0}};
            if (!step_last_s) begin
              gen_inc_nxt_s  = step_nxt_s;
              step_idx_nxt_s = step_idx_r + 16'd1;
            end else if (mode_sh_r == SWEEP_CONT) begin
              gen_inc_nxt_s  = start_sh_r;
              step_idx_nxt_s = {INC_W{1'b0}};
              wrap_nxt_s     = 1'b1;
            end else begin
              state_nxt_s  = DONE;
              done_nxt_s   = 1'b1;
              gen_en_nxt_s = 1'b0;
              busy_nxt_s   = 1'b0;
            end
          end else if (acc_s) begin
            dwell_cnt_nxt_s = dwell_cnt_r + DWELL_W'(1);
          end else begin
            dwell_cnt_nxt_s = dwell_cnt_r;
          end
        end
      end
      DONE: begin
        if (!ctrl_en_q_i) begin
          state_nxt_s    = IDLE;
          gen_inc_nxt_s  = {INC_W{1'b0}};
          step_idx_nxt_s = {INC_W{1'b0}};
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        gen_inc_nxt_s   = {INC_W{1'b0}};
        step_idx_nxt_s  = {INC_W{1'b0}};
        dwell_cnt_nxt_s = {DWELL_W{1'b0}};
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dwell_cnt_r <= {DWELL_W{1'b0}};
      gen_en_r    <= 1'b0;
      gen_inc_r   <= {INC_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wrap_r      <= 1'b0;
      step_idx_r  <= {INC_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      dwell_cnt_r <= dwell_cnt_nxt_s;
      gen_en_r    <= gen_en_nxt_s;
      gen_inc_r   <= gen_inc_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      wrap_r      <= wrap_nxt_s;
      step_idx_r  <= step_idx_nxt_s;
    end
  end

  // Shadow copies of the sweep settings, captured only on arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sh_r <= {INC_W{1'b0}};
      stop_sh_r  <= {INC_W{1'b0}};
      step_sh_r  <= {INC_W{1'b0}};
      dwell_sh_r <= {DWELL_W{1'b0}};
      mode_sh_r  <= SWEEP_ONESHOT;
      down_sh_r  <= 1'b0;
    end else if (load_s) begin
      start_sh_r <= start_inc_q_i;
      stop_sh_r  <= stop_inc_q_i;
      step_sh_r  <= step_inc_q_i;
      dwell_sh_r <= dwell_q_i;
      mode_sh_r  <= ctrl_mode_q_i;
`ifdef WFG_STIM_SWEEP_DOWN_EN
      down_sh_r  <= (start_inc_q_i > stop_inc_q_i);
`else
      down_sh_r  <= 1'b0;
`endif
    end else begin
      start_sh_r <= start_sh_r;
    end
  end

  assign gen_en_o   = gen_en_r;
  assign gen_inc_o  = gen_inc_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign wrap_o     = wrap_r;
  assign step_idx_o = step_idx_r;

endmodule

// File: tb/tb_wfg_stim_sweep_ctrl.sv
// Directed and randomized bench for wfg_stim_sweep_ctrl against a sweep reference model.
module tb_wfg_stim_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] start_v = 16'd0, stop_v = 16'd0, step_v = 16'd0, dwell_v = 16'd0;
  logic        tvalid = 1'b0, tready = 1'b0;
  logic        gen_en_o, busy_o, done_o, wrap_o;
  logic [15:0] gen_inc_o, step_idx_o;

  int checks = 0;
  int failures = 0;

  // reference model
  bit m_run, m_fin, m_down, m_mode;
  int m_cnt, m_start, m_stop, m_step, m_dwell;
  int m_en, m_inc, m_busy, m_done, m_wrap, m_idx;

  wfg_stim_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl_en_q_i(en), .ctrl_mode_q_i(mode),
    .start_inc_q_i(start_v), .stop_inc_q_i(stop_v), .step_inc_q_i(step_v),
    .dwell_q_i(dwell_v), .gen_axis_tvalid_i(tvalid), .gen_axis_tready_i(tready),
    .gen_en_o(gen_en_o), .gen_inc_o(gen_inc_o), .busy_o(busy_o), .done_o(done_o),
    .wrap_o(wrap_o), .step_idx_o(step_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic zero_outs();
    m_en = 0; m_inc = 0; m_busy = 0; m_idx = 0; m_cnt = 0;
  endtask

  // Applies one clock of the sweep rules to the model using current inputs.
  task automatic model_step();
    bit acc;
    bit last;
    int nxt;
    int dw;
    acc = tvalid & tready;
    m_done = 0; m_wrap = 0;
    if (rst) begin
      m_run = 0; m_fin = 0; zero_outs();
    end else if (m_run) begin
      if (!en) begin
        m_run = 0; zero_outs();
      end else if (acc) begin
        m_cnt++;
        dw = (m_dwell == 0) ? 1 : m_dwell;
        if (m_cnt >= dw) begin
          m_cnt = 0;
          nxt  = m_down ? (m_inc - m_step) : (m_inc + m_step);
          last = m_down ? (nxt < m_stop) : (nxt > m_stop);
          if (!last) begin
            m_inc = nxt; m_idx = (m_idx + 1) % 65536;
          end else if (m_mode) begin
            m_inc = m_start; m_idx = 0; m_wrap = 1;
          end else begin
            m_run = 0; m_fin = 1; m_done = 1; m_en = 0; m_busy = 0;
          end
        end
      end
    end else if (m_fin) begin
      if (!en) begin
        m_fin = 0; zero_outs();
      end
    end else begin
      zero_outs();
      if (en) begin
        m_start = start_v; m_stop = stop_v; m_step = step_v; m_dwell = dwell_v; m_mode = mode;
`ifdef WFG_STIM_SWEEP_DOWN_EN
        m_down = (start_v > stop_v);
`else
        m_down = 0;
`endif
        m_run = 1; m_en = 1; m_busy = 1; m_inc = m_start;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".gen_en"}, 32'(gen_en_o), m_en);
    chk({tag, ".gen_inc"}, 32'(gen_inc_o), m_inc);
    chk({tag, ".busy"}, 32'(busy_o), m_busy);
    chk({tag, ".done"}, 32'(done_o), m_done);
    chk({tag, ".wrap"}, 32'(wrap_o), m_wrap);
    chk({tag, ".step_idx"}, 32'(step_idx_o), m_idx);
  endtask

  task automatic cfg(input int s, input int p, input int st, input int d, input bit md);
    start_v = 16'(s); stop_v = 16'(p); step_v = 16'(st); dwell_v = 16'(d); mode = md;
  endtask

  initial begin
    tick("reset");
    chk("reset_en", 32'(gen_en_o), 32'd0);
    chk("reset_inc", 32'(gen_inc_o), 32'd0);
    rst = 1'b0;

    // one-shot sweep 100,150,200
    cfg(100, 220, 50, 3, 1'b0); tvalid = 1'b1; tready = 1'b1; en = 1'b1;
    tick("os_arm");
    chk("os_arm_inc", 32'(gen_inc_o), 32'd100);
    chk("os_arm_en", 32'(gen_en_o), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      tick("os");
      if (k == 3) chk("os_inc150", 32'(gen_inc_o), 32'd150);
      if (k == 6) chk("os_inc200", 32'(gen_inc_o), 32'd200);
    end
    chk("os_done", 32'(done_o), 32'd1);
    chk("os_en_off", 32'(gen_en_o), 32'd0);
    chk("os_hold", 32'(gen_inc_o), 32'd200);
    tick("os_after");
    chk("os_done_pulse", 32'(done_o), 32'd0);
    en = 1'b0; tick("os_idle");

    // continuous sweep wraps to start
    mode = 1'b1; en = 1'b1; tick("ct_arm");
    for (int k = 1; k <= 9; k++) begin
      tick("ct");
      if (k == 8) chk("ct_idx2", 32'(step_idx_o), 32'd2);
    end
    chk("ct_inc", 32'(gen_inc_o), 32'd100);
    chk("ct_wrap", 32'(wrap_o), 32'd1);
    chk("ct_idx0", 32'(step_idx_o), 32'd0);
    chk("ct_busy", 32'(busy_o), 32'd1);
    en = 1'b0; tick("ct_idle");

    // backpressure: only accepted cycles count
    cfg(10, 1000, 5, 2, 1'b0); tready = 1'b0; en = 1'b1; tick("bp_arm");
    for (int k = 1; k <= 8; k++) begin
      tready = (k % 2 == 1);
      tick("bp");
      if (k == 3) chk("bp_inc15", 32'(gen_inc_o), 32'd15);
      if (k == 6) chk("bp_hold15", 32'(gen_inc_o), 32'd15);
      if (k == 7) chk("bp_inc20", 32'(gen_inc_o), 32'd20);
    end
    en = 1'b0; tready = 1'b1; tick("bp_idle");

    // abort coinciding with a step-ending accept
    cfg(100, 220, 50, 3, 1'b0); en = 1'b1; tick("ab_arm");
    tick("ab"); tick("ab");
    en = 1'b0; tick("ab_drop");
    chk("ab_en", 32'(gen_en_o), 32'd0);
    chk("ab_inc", 32'(gen_inc_o), 32'd0);
    chk("ab_done", 32'(done_o), 32'd0);

    // carry past 0xFFFF ends the sweep
    cfg(16'hFFF0, 16'hFFFF, 16'h20, 1, 1'b0); en = 1'b1; tick("cy_arm");
    tick("cy");
    chk("cy_done", 32'(done_o), 32'd1);
    en = 1'b0; tick("cy_idle");

    // start above stop
    cfg(300, 200, 50, 1, 1'b0); en = 1'b1; tick("dn_arm");
`ifdef WFG_STIM_SWEEP_DOWN_EN
    tick("dn"); chk("dn_250", 32'(gen_inc_o), 32'd250);
    tick("dn"); chk("dn_200", 32'(gen_inc_o), 32'd200);
    tick("dn"); chk("dn_done", 32'(done_o), 32'd1);
`else
    tick("dn"); chk("up_only_done", 32'(done_o), 32'd1);
    chk("up_only_hold", 32'(gen_inc_o), 32'd300);
`endif
    en = 1'b0; tick("dn_idle");

    // dwell 0 acts as dwell 1
    cfg(5, 100, 1, 0, 1'b0); en = 1'b1; tick("d0_arm");
    tick("d0"); chk("d0_inc6", 32'(gen_inc_o), 32'd6);
    tick("d0"); chk("d0_inc7", 32'(gen_inc_o), 32'd7);
    en = 1'b0; tick("d0_idle");

    // reset mid-run, then restart with enable held
    cfg(100, 220, 50, 3, 1'b0); en = 1'b1; tick("rs_arm");
    tick("rs"); tick("rs"); tick("rs");
    rst = 1'b1; tick("rs_rst");
    chk("rs_en", 32'(gen_en_o), 32'd0);
    chk("rs_inc", 32'(gen_inc_o), 32'd0);
    chk("rs_busy", 32'(busy_o), 32'd0);
    rst = 1'b0; tick("rs_rearm");
    chk("rs_restart_inc", 32'(gen_inc_o), 32'd100);
    chk("rs_restart_en", 32'(gen_en_o), 32'd1);
    en = 1'b0; tick("rs_idle");

    // randomized traffic and live register changes
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 7) == 0)
          cfg(16'hFF00 + $urandom_range(0, 255), 16'hFFF0 + $urandom_range(0, 15),
              $urandom_range(0, 64), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        else
          cfg($urandom_range(0, 600), $urandom_range(0, 800), $urandom_range(0, 120),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      en     = ($urandom_range(0, 19) != 0);
      tvalid = ($urandom_range(0, 3) != 0);
      tready = ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      tick("rnd");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
